// File: rtl/gfx_pkg.sv
// Shared encodings for the GFX block: rectangle fill modes, filler FSM states
// and default VRAM geometry.
package gfx_pkg;

    localparam int DEF_COL_W = 6;
    localparam int DEF_ROW_W = 4;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        BORDER  = 2'd1,
        CLEAR   = 2'd2,
        CORNERS = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_IRQ = 3'd1,
        ACK      = 3'd2,
        WRITE    = 3'd3,
        END      = 3'd4
    } state_e;

endpackage

// File: rtl/rect_cursor.sv
// Raster cursor over an inclusive rectangle. Exposes the cell it will hold next
// cycle so the parent can register its VRAM outputs in step with the cursor.
module rect_cursor #(
    parameter int COL_W = gfx_pkg::DEF_COL_W,
    parameter int ROW_W = gfx_pkg::DEF_ROW_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [COL_W-1:0] i_x0,
    input  logic [COL_W-1:0] i_x1,
    input  logic [ROW_W-1:0] i_y0,
    input  logic [ROW_W-1:0] i_y1,
    output logic             o_last,
    output logic [COL_W-1:0] o_nx,
    output logic [ROW_W-1:0] o_ny,
    output logic             o_next_edge,
    output logic             o_next_corner
);

    logic [COL_W-1:0] r_x, w_nx;
    logic [ROW_W-1:0] r_y, w_ny;
    logic             w_x_edge, w_y_edge;

    always_comb begin
        w_nx = r_x;
        w_ny = r_y;
        if (i_load) begin
            w_nx = i_x0;
            w_ny = i_y0;
        end else if (i_step) begin
            if (r_x == i_x1) begin
                w_nx = i_x0;
                w_ny = r_y + ROW_W'(1);
            end else begin
                w_nx = r_x + COL_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_nx;
            r_y <= w_ny;
        end
    end

    // Flags describe the upcoming cell, not the current one.
    assign w_x_edge      = (w_nx == i_x0) || (w_nx == i_x1);
    assign w_y_edge      = (w_ny == i_y0) || (w_ny == i_y1);
    assign o_next_edge   = w_x_edge || w_y_edge;
    assign o_next_corner = w_x_edge && w_y_edge;
    assign o_last        = (r_x == i_x1) && (r_y == i_y1);
    assign o_nx          = w_nx;
    assign o_ny          = w_ny;

endmodule

// File: rtl/vram_rect_filler.sv
// Rectangle fill engine: waits for the vblank interrupt, then streams one VRAM
// write strobe per rectangle cell in raster order.
module vram_rect_filler
    import gfx_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                COL_W     = DEF_COL_W,
    parameter int                ROW_W     = DEF_ROW_W,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_MODE,
    input  logic [COL_W-1:0]  CMD_X0,
    input  logic [COL_W-1:0]  CMD_X1,
    input  logic [ROW_W-1:0]  CMD_Y0,
    input  logic [ROW_W-1:0]  CMD_Y1,
    input  logic [DATA_W-1:0] CMD_DATA,
    input  logic              INTC_IRQ,
    output logic              INTC_IACK,
    output logic              INTC_IEND,
    output logic              MEMC_RAM_ENABLE,
    output logic              MEMC_RAM_WRITE,
    output logic [ADDR_W-1:0] MEMC_RAM_ADDR,
    output logic [DATA_W-1:0] MEMC_RAM_DATA_W,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    state_e            r_state, w_next;
    mode_e             r_mode;
    logic [COL_W-1:0]  r_x0, r_x1;
    logic [ROW_W-1:0]  r_y0, r_y1;
    logic [DATA_W-1:0] r_data;
    logic              r_err, r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept, w_bad, w_load, w_step, w_last, w_cell_we, w_wr_next;
    logic              w_next_edge, w_next_corner;
    logic [COL_W-1:0]  w_nx;
    logic [ROW_W-1:0]  w_ny;

    assign w_accept = CMD_VALID && (r_state == IDLE);
    assign w_bad    = (CMD_X1 < CMD_X0) || (CMD_Y1 < CMD_Y0);
    assign w_load   = (r_state == ACK);
    assign w_step   = (r_state == WRITE) && !w_last;

    rect_cursor #(.COL_W(COL_W), .ROW_W(ROW_W)) u_cursor (
        .CLK           (CLK),
        .RESET         (RESET),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_x0          (r_x0),
        .i_x1          (r_x1),
        .i_y0          (r_y0),
        .i_y1          (r_y1),
        .o_last        (w_last),
        .o_nx          (w_nx),
        .o_ny          (w_ny),
        .o_next_edge   (w_next_edge),
        .o_next_corner (w_next_corner)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept && !w_bad) w_next = WAIT_IRQ;
            WAIT_IRQ: if (INTC_IRQ) w_next = ACK;
            ACK:      w_next = WRITE;
            WRITE:    if (w_last) w_next = END;
            END:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_cell_we = 1'b1;
        case (r_mode)
            BORDER:  w_cell_we = w_next_edge;
            CORNERS: w_cell_we = w_next_corner;
            default: w_cell_we = 1'b1;
        endcase
    end

    // Strobes are registered off the next state so they line up with the cell.
    assign w_wr_next = (w_next == WRITE) && w_cell_we;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_mode  <= FILL;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_en    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_bad) begin
                r_mode <= mode_e'(CMD_MODE);
                r_x0   <= CMD_X0;
                r_x1   <= CMD_X1;
                r_y0   <= CMD_Y0;
                r_y1   <= CMD_Y1;
                r_data <= CMD_DATA;
            end
            r_err   <= w_accept && w_bad;
            r_en    <= w_wr_next;
            r_addr  <= (w_next == WRITE) ? BASE_ADDR + ADDR_W'({w_ny, w_nx}) : '0;
            r_wdata <= (w_wr_next && r_mode != CLEAR) ? r_data : '0;
        end
    end

    assign CMD_READY       = (r_state == IDLE);
    assign BUSY            = (r_state != IDLE);
    assign INTC_IACK       = (r_state == ACK);
    assign INTC_IEND       = (r_state == END);
    assign DONE            = (r_state == END);
    assign ERR             = r_err;
    assign MEMC_RAM_ENABLE = r_en;
    assign MEMC_RAM_WRITE  = r_en;
    assign MEMC_RAM_ADDR   = r_addr;
    assign MEMC_RAM_DATA_W = r_wdata;

endmodule
